// File: rtl/divisor_pkg.sv
// Shared defaults and per-cycle step encoding for the programmable clock divider.
package divisor_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDiv   = 32050;

    typedef enum logic [1:0] {
        StepHold,
        StepCount,
        StepWrap,
        StepApply
    } step_e;

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: counter, active/shadow terminal count and glitch-free divisor swap.
module divisor_canal
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
    input  logic             Clock_in,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Load,
    output logic             Clock_out,
    output logic             Tick,
    output logic             Pending
);

    localparam logic [WIDTH-1:0] DivInit = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    step_e            step;

    // >= rather than == so an out-of-range count still wraps
    always_comb begin
        if (Enable) begin
            step = (cnt_q >= act_q) ? StepWrap : StepCount;
        end else begin
            step = pend_q ? StepApply : StepHold;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        unique case (step)
            StepHold:  ;
            StepCount: cnt_d = cnt_q + WIDTH'(1);
            StepWrap: begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (pend_q) begin
                    act_d  = sh_q;
                    pend_d = 1'b0;
                end
            end
            StepApply: begin
                act_d  = sh_q;
                cnt_d  = '0;
                pend_d = 1'b0;
            end
        endcase
        // A Load coinciding with a swap lands in the shadow and stays pending
        if (Load) begin
            sh_d   = Divisor;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge Clock_in or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q  <= '0;
            act_q  <= DivInit;
            sh_q   <= DivInit;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign Clock_out = clk_q;
    assign Tick      = tick_q;
    assign Pending   = pend_q;

endmodule

// File: rtl/divisor_programable.sv
// Multi-channel programmable clock divider; each channel is an independent divisor_canal.
module divisor_programable
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
    input  logic                      Clock_in,
    input  logic                      Reset_n,
    input  logic [CHANNELS-1:0]       Enable,
    input  logic [CHANNELS*WIDTH-1:0] Divisor,
    input  logic [CHANNELS-1:0]       Load,
    output logic [CHANNELS-1:0]       Clock_out,
    output logic [CHANNELS-1:0]       Tick,
    output logic [CHANNELS-1:0]       Pending
);

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_canal
        divisor_canal #(
            .WIDTH      (WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_canal (
            .Clock_in (Clock_in),
            .Reset_n  (Reset_n),
            .Enable   (Enable[i]),
            .Divisor  (Divisor[i*WIDTH +: WIDTH]),
            .Load     (Load[i]),
            .Clock_out(Clock_out[i]),
            .Tick     (Tick[i]),
            .Pending  (Pending[i])
        );
    end

endmodule
